wash_cycle_controller: RTL and testbench

Top-level sequencer for the washing-machine controller. It walks a wash program (lock, fill, heat, wash, rinse passes, spin, done) and drives the 3-bit `state` bus consumed by the phase timer. It advances on the timer's `sig_Full`, `sig_Temperature` and `sig_Completed` flags and drives the actuator enables. It also handles the door interlock, cancel and a per-phase watchdog.

---
 rtl/wm_pkg.sv | 69 ++++++
 rtl/phase_watchdog.sv | 33 +++
 rtl/wash_cycle_controller.sv | 150 +++++++++++++++
 tb/tb_wash_cycle_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine controller.
//   - Eight state codes. Codes 2..6 are also the phase codes the timer decodes.
//   - Default watchdog limit.
//   - Actuator bundle and its Moore decode.
package wm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOCK  = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_HEAT  = 3'd3;
  localparam logic [2:0] ST_WASH  = 3'd4;
  localparam logic [2:0] ST_RINSE = 3'd5;
  localparam logic [2:0] ST_SPIN  = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Timer phase codes share the controller encoding.
  localparam logic [2:0] PH_FILL  = ST_FILL;
  localparam logic [2:0] PH_HEAT  = ST_HEAT;
  localparam logic [2:0] PH_WASH  = ST_WASH;
  localparam logic [2:0] PH_RINSE = ST_RINSE;
  localparam logic [2:0] PH_SPIN  = ST_SPIN;

  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOCK  = ST_LOCK,
    S_FILL  = ST_FILL,
    S_HEAT  = ST_HEAT,
    S_WASH  = ST_WASH,
    S_RINSE = ST_RINSE,
    S_SPIN  = ST_SPIN,
    S_DONE  = ST_DONE
  } wm_state_e;

  typedef struct packed {
    logic door_lock;
    logic water_valve;
    logic heater;
    logic motor_on;
    logic motor_fast;
    logic drain_valve;
    logic done;
  } act_t;

  // LOCK..SPIN: phases guarded by the watchdog.
  function automatic logic in_active(wm_state_e s);
    return (s >= S_LOCK) && (s <= S_SPIN);
  endfunction

  // FILL..SPIN: phases with the door interlock enforced (and pausable).
  function automatic logic in_wet(wm_state_e s);
    return (s >= S_FILL) && (s <= S_SPIN);
  endfunction

  function automatic act_t decode_act(wm_state_e s);
    act_t a;
    a             = '0;
    a.door_lock   = in_active(s);
    a.water_valve = (s == S_FILL);
    a.heater      = (s == S_HEAT);
    a.motor_on    = (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
    a.motor_fast  = (s == S_SPIN);
    a.drain_valve = (s == S_SPIN);
    a.done        = (s == S_DONE);
    return a;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle watchdog.
//   clock, reset : system clock, async active-high reset
//   clear        : restart count (phase entry / outside guarded phases)
//   hold         : freeze count
//   enable       : count while in a guarded phase
//   expired      : high on the edge that completes the TIMEOUT_CYCLES-th cycle
module phase_watchdog #(
  parameter int WD_W           = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  input  logic enable,
  output logic expired
);

  // cnt_q is 0 during the first cycle of a phase, so the edge that ends
  // cycle N sees cnt_q == N-1.
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] cnt_q;

  assign expired = enable && !hold && (cnt_q == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 cnt_q <= '0;
    else if (clear)                            cnt_q <= '0;
    else if (enable && !hold && cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/wash_cycle_controller.sv
// Wash program sequencer: IDLE, LOCK, FILL, HEAT, WASH, (FILL, RINSE) x N,
// SPIN, DONE. Advances on timer flags and handles door interlock, cancel and
// a per-phase watchdog.
//   clock, reset                          : clock, async active-high reset
//   start, cancel, door_closed            : operator / sensor inputs
//   sig_Full, sig_Temperature, sig_Completed : timer flags
//   pause                                 : hold request (WM_PAUSE_EN only)
//   state                                 : phase code to the timer
//   door_lock, water_valve, heater, motor_on, motor_fast, drain_valve : actuators
//   done                                  : one-cycle end-of-program pulse
//   fault                                 : sticky, cleared by accepted start
// Optional feature macro: WM_PAUSE_EN.
module wash_cycle_controller
  import wm_pkg::*;
#(
  parameter int RINSE_PASSES   = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int WD_W           = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
`ifdef WM_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] state,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain_valve,
  output logic       done,
  output logic       fault
);

  wm_state_e state_q, state_d;
  logic      first_q;              // first cycle of a phase: timer flags blanked
  logic      refill_q, refill_d;   // set once the main wash has completed
  logic [1:0] pass_q, pass_d;
  logic      fault_q, fault_d;
  act_t      act_q;
  logic      paused;
  logic      flags_ok;
  logic      door_fault;
  logic      wd_expired;

`ifdef WM_PAUSE_EN
  assign paused = pause && in_wet(state_q);
`else
  assign paused = 1'b0;
`endif

  assign flags_ok   = !first_q;
  assign door_fault = in_wet(state_q) && !door_closed;

  phase_watchdog #(
    .WD_W          (WD_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state_d != state_q) || !in_active(state_q)),
    .hold   (paused),
    .enable (in_active(state_q)),
    .expired(wd_expired)
  );

  // Next state, priority: door fault, watchdog, cancel, (pause hold), advance.
  always_comb begin
    state_d  = state_q;
    refill_d = refill_q;
    pass_d   = pass_q;
    fault_d  = fault_q;
    if (door_fault) begin
      state_d = S_IDLE;
      fault_d = 1'b1;
    end else if (wd_expired) begin
      state_d = S_IDLE;
      fault_d = 1'b1;
    end else if (cancel && state_q == S_LOCK) begin
      state_d = S_IDLE;
    end else if (cancel && state_q >= S_FILL && state_q <= S_RINSE) begin
      state_d = S_SPIN;
    end else if (!paused) begin
      case (state_q)
        S_IDLE: if (start && door_closed) begin
          state_d  = S_LOCK;
          fault_d  = 1'b0;
          refill_d = 1'b0;
          pass_d   = '0;
        end
        // Lock confirmed only once the solenoid output is actually driven.
        S_LOCK: if (door_closed && act_q.door_lock) state_d = S_FILL;
        S_FILL: if (flags_ok && sig_Full)
          state_d = refill_q ? S_RINSE : S_HEAT;
        S_HEAT: if (flags_ok && sig_Temperature) state_d = S_WASH;
        S_WASH: if (flags_ok && sig_Completed) begin
          state_d  = S_FILL;
          refill_d = 1'b1;
        end
        S_RINSE: if (flags_ok && sig_Completed) begin
          pass_d  = pass_q + 2'd1;
          state_d = (int'(pass_q) + 1 < RINSE_PASSES) ? S_FILL : S_SPIN;
        end
        S_SPIN: if (flags_ok && sig_Completed) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b1;
      refill_q <= 1'b0;
      pass_q   <= '0;
      fault_q  <= 1'b0;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      // A paused cycle re-arms blanking so the restarted phase ignores
      // whatever the stopped timer left on its flags.
      first_q  <= (state_d != state_q) || paused;
      refill_q <= refill_d;
      pass_q   <= pass_d;
      fault_q  <= fault_d;
      act_q    <= decode_act(state_d);
    end
  end

  // While paused the timer sees the LOCK code and all actuators except the
  // door lock are forced off.
  assign state       = paused ? ST_LOCK : state_q;
  assign door_lock   = act_q.door_lock;
  assign water_valve = act_q.water_valve & ~paused;
  assign heater      = act_q.heater      & ~paused;
  assign motor_on    = act_q.motor_on    & ~paused;
  assign motor_fast  = act_q.motor_fast  & ~paused;
  assign drain_valve = act_q.drain_valve & ~paused;
  assign done        = act_q.done;
  assign fault       = fault_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
module tb_wash_cycle_controller;

  logic       clock = 1'b0;
  logic       reset, start, cancel, door_closed;
  logic       sig_Full, sig_Temperature, sig_Completed;
`ifdef WM_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] state;
  logic       door_lock, water_valve, heater, motor_on, motor_fast, drain_valve, done, fault;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  wash_cycle_controller #(
    .RINSE_PASSES  (2),
    .TIMEOUT_CYCLES(15),
    .WD_W          (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .cancel         (cancel),
    .door_closed    (door_closed),
    .sig_Full       (sig_Full),
    .sig_Temperature(sig_Temperature),
    .sig_Completed  (sig_Completed),
`ifdef WM_PAUSE_EN
    .pause          (pause),
`endif
    .state          (state),
    .door_lock      (door_lock),
    .water_valve    (water_valve),
    .heater         (heater),
    .motor_on       (motor_on),
    .motor_fast     (motor_fast),
    .drain_valve    (drain_valve),
    .done           (done),
    .fault          (fault)
  );

  typedef struct {
    logic       st, ca, dr, fu, te, co;
    logic [2:0] es;
    logic       ef;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic ca, logic dr, logic fu, logic te,
                              logic co, logic [2:0] es, logic ef);
    vec_t v;
    v.st = st; v.ca = ca; v.dr = dr; v.fu = fu; v.te = te; v.co = co;
    v.es = es; v.ef = ef;
    return v;
  endfunction

  // {door_lock, water_valve, heater, motor_on, motor_fast, drain_valve, done}
  function automatic logic [6:0] exp_act(logic [2:0] s);
    case (s)
      3'd1:    return 7'b1000000;
      3'd2:    return 7'b1100000;
      3'd3:    return 7'b1010000;
      3'd4:    return 7'b1001000;
      3'd5:    return 7'b1001000;
      3'd6:    return 7'b1001110;
      3'd7:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] act_now();
    return {door_lock, water_valve, heater, motor_on, motor_fast, drain_valve, done};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ca, input logic dr,
                       input logic fu, input logic te, input logic co);
    start = st; cancel = ca; door_closed = dr;
    sig_Full = fu; sig_Temperature = te; sig_Completed = co;
  endtask

  task automatic step(input logic st, input logic ca, input logic dr,
                      input logic fu, input logic te, input logic co);
    drive(st, ca, dr, fu, te, co);
    @(posedge clock); #1;
  endtask

  task automatic chk_state(input string nm, input logic [2:0] es, input logic ef);
    chk({nm, ".state"}, 16'(state), 16'(es));
    chk({nm, ".fault"}, 16'(fault), 16'(ef));
    chk({nm, ".act"},   16'(act_now()), 16'(exp_act(es)));
  endtask

  int n;

  initial begin
    reset = 1'b1;
`ifdef WM_PAUSE_EN
    pause = 1'b0;
`endif
    drive(0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk_state("reset", 3'd0, 1'b0);
    reset = 1'b0;

    //          st ca dr fu te co  state fault
    // normal program with flags held into each new phase (blanking)
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3'd2, 0)); // blanked
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd3, 0)); // blanked
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd4, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd4, 0)); // blanked
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0)); // refill
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 0)); // stale completed
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd2, 0)); // pass 1
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 3'd5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd6, 0)); // pass 2
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd6, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd7, 0)); // done pulse
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, 0));
    // door opens in WASH
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 3'd4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 1)); // start, door open: ignored
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd1, 0)); // accepted start clears fault
    // cancel in HEAT, then cancel ignored in SPIN
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3'd3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3'd6, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3'd6, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3'd6, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 3'd7, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3'd0, 0));
    // cancel in LOCK, start with door open
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3'd1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3'd0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].ca, tbl[i].dr, tbl[i].fu, tbl[i].te, tbl[i].co);
      chk_state($sformatf("vec%0d", i), tbl[i].es, tbl[i].ef);
    end

    // watchdog in FILL: exactly 15 cycles
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("wd_fill.entry", 16'(state), 16'd2);
    n = 1;
    while (state == 3'd2 && n < 40) begin
      @(posedge clock); #1;
      if (state == 3'd2) n++;
    end
    chk("wd_fill.cycles", 16'(n), 16'd15);
    chk_state("wd_fill.after", 3'd0, 1'b1);

    // watchdog in LOCK with door left open
    step(1, 0, 1, 0, 0, 0);
    chk_state("wd_lock.entry", 3'd1, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    n = 1;
    while (state == 3'd1 && n < 40) begin
      @(posedge clock); #1;
      if (state == 3'd1) n++;
    end
    chk("wd_lock.cycles", 16'(n), 16'd15);
    chk_state("wd_lock.after", 3'd0, 1'b1);

    // flag on the expiry edge: fault wins
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("wd_race.entry", 16'(state), 16'd2);
    repeat (14) step(0, 0, 1, 0, 0, 0);
    chk("wd_race.pre", 16'(state), 16'd2);
    step(0, 0, 1, 1, 0, 0);
    chk_state("wd_race.after", 3'd0, 1'b1);

    // async reset mid-program (WASH)
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    chk_state("pre_rst", 3'd4, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_state("async_rst", 3'd0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

`ifdef WM_PAUSE_EN
    // reach RINSE
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("pause.rinse", 16'(state), 16'd5);
    pause = 1'b1;
    #1;
    chk("pause.state0", 16'(state), 16'd1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 0, 1);
      chk($sformatf("pause.state%0d", k + 1), 16'(state), 16'd1);
      chk($sformatf("pause.act%0d", k + 1), 16'(act_now()), 16'b1000000);
    end
    pause = 1'b0;
    #1;
    chk("pause.release", 16'(state), 16'd5);
    step(0, 0, 1, 0, 0, 1);
    chk("pause.blank", 16'(state), 16'd5);
    step(0, 0, 1, 0, 0, 1);
    chk("pause.advance", 16'(state), 16'd2);
    pause = 1'b1;
    step(0, 0, 1, 0, 0, 0);
    chk("pause2.state", 16'(state), 16'd1);
    #2 reset = 1'b1;
    #1;
    pause = 1'b0;
    #1;
    chk_state("pause_rst", 3'd0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
